bht_update_ctrl: RTL and testbench

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

---
 rtl/bht_update_ctrl.sv | 150 +++++++++++++++
 tb/tb_bht_update_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: buffers committed branch outcomes from the ROB in a small
// circular FIFO and replays them to the BHT one per cycle. The BHT can be frozen
// while the FIFO keeps buffering, and two statistics counters track what was issued.
module bht_update_ctrl #(
  parameter int BHT_IDX_W  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rob_upd_valid,
  input  logic [BHT_IDX_W-1:0] rob_upd_id,
  input  logic                 rob_upd_mispred,
  output logic                 rob_upd_ready,
  input  logic                 freeze,
  output logic                 bht_needchange,
  output logic                 bht_needchange2,
  output logic [BHT_IDX_W-1:0] bht_id,
  input  logic [BHT_IDX_W-1:0] lookup_id,
  output logic                 lookup_pending,
  input  logic                 cnt_clr,
  output logic [15:0]          upd_cnt,
  output logic [15:0]          mispred_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FROZEN
  } state_t;

  state_t               state;
  logic [BHT_IDX_W-1:0] entry_id      [FIFO_DEPTH];
  logic                 entry_mispred [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic                 push;
  logic                 pop;
  logic [BHT_IDX_W-1:0] head_id;
  logic                 head_mispred;
  logic                 pulse_active;
  logic                 lookup_hit;
  logic [PTR_W-1:0]     slot_off;

  // Handshake and transfer qualifiers; rst is folded in so ready drops at once in reset.
  assign rob_upd_ready = (count != FULL_COUNT) && rdy && rst;
  assign push          = rob_upd_valid && rob_upd_ready;
  assign pop           = (state == ACTIVE) && rdy && (count != '0);
  assign head_id       = entry_id[rd_ptr];
  assign head_mispred  = entry_mispred[rd_ptr];
  assign pulse_active  = bht_needchange || bht_needchange2;

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Scan the occupied slots (head onward) for an update to the index being predicted.
  always_comb begin
    lookup_hit = 1'b0;
    slot_off   = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = PTR_W'(i) - rd_ptr;
      if (({1'b0, slot_off} < count) && (entry_id[i] == lookup_id)) begin
        lookup_hit = 1'b1;
      end
    end
  end

  assign lookup_pending = lookup_hit || (pulse_active && (bht_id == lookup_id));

  // FIFO payload storage; occupancy is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_id[wr_ptr]      <= rob_upd_id;
      entry_mispred[wr_ptr] <= rob_upd_mispred;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Drain state machine with registered one-cycle update pulses toward the BHT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      bht_needchange  <= 1'b0;
      bht_needchange2 <= 1'b0;
      bht_id          <= '0;
    end else begin
      if (rdy) begin
        if (freeze) begin
          state <= FROZEN;
        end else if (count_next != '0) begin
          state <= ACTIVE;
        end else begin
          state <= IDLE;
        end
      end
      if (pop) begin
        bht_needchange  <= head_mispred;
        bht_needchange2 <= ~head_mispred;
        bht_id          <= head_id;
      end else begin
        bht_needchange  <= 1'b0;
        bht_needchange2 <= 1'b0;
      end
    end
  end

  // Statistics: clear has priority over counting a pop; the mispredict count saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_cnt     <= '0;
      mispred_cnt <= '0;
    end else if (rdy) begin
      if (cnt_clr) begin
        upd_cnt     <= '0;
        mispred_cnt <= '0;
      end else if (pop) begin
        upd_cnt <= upd_cnt + 16'd1;
        if (head_mispred && (mispred_cnt != 16'hFFFF)) begin
          mispred_cnt <= mispred_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb_bht_update_ctrl: drives directed scenarios and randomized traffic into
// bht_update_ctrl and compares every output each cycle against a queue-based model.
module tb_bht_update_ctrl;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rdy = 1'b0;
  logic         rob_upd_valid = 1'b0;
  logic [W-1:0] rob_upd_id = '0;
  logic         rob_upd_mispred = 1'b0;
  logic         rob_upd_ready;
  logic         freeze = 1'b0;
  logic         bht_needchange;
  logic         bht_needchange2;
  logic [W-1:0] bht_id;
  logic [W-1:0] lookup_id = '0;
  logic         lookup_pending;
  logic         cnt_clr = 1'b0;
  logic [15:0]  upd_cnt;
  logic [15:0]  mispred_cnt;

  int checks = 0;
  int errors = 0;

  bht_update_ctrl #(
    .BHT_IDX_W (W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rob_upd_valid  (rob_upd_valid),
    .rob_upd_id     (rob_upd_id),
    .rob_upd_mispred(rob_upd_mispred),
    .rob_upd_ready  (rob_upd_ready),
    .freeze         (freeze),
    .bht_needchange (bht_needchange),
    .bht_needchange2(bht_needchange2),
    .bht_id         (bht_id),
    .lookup_id      (lookup_id),
    .lookup_pending (lookup_pending),
    .cnt_clr        (cnt_clr),
    .upd_cnt        (upd_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // One comparison: counts it, and reports it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Presents one cycle of inputs, changed just after a rising edge.
  task automatic applyStimulus(input bit v, input logic [W-1:0] id, input bit mp, input bit frz,
                               input bit rd, input bit clr, input logic [W-1:0] lid);
    @(posedge clk);
    #1;
    rob_upd_valid   = v;
    rob_upd_id      = id;
    rob_upd_mispred = mp;
    freeze          = frz;
    rdy             = rd;
    cnt_clr         = clr;
    lookup_id       = lid;
  endtask

  task automatic idleCycle(input bit frz, input logic [W-1:0] lid);
    applyStimulus(1'b0, '0, 1'b0, frz, 1'b1, 1'b0, lid);
  endtask

  // Reference model: pending updates as a queue, plus the expected registered outputs.
  logic [W-1:0] q_id[$];
  logic         q_mp[$];
  bit           m_drain = 1'b0;
  bit           m_nc = 1'b0;
  bit           m_nc2 = 1'b0;
  logic [W-1:0] m_bid = '0;
  logic [15:0]  m_upd = '0;
  logic [15:0]  m_mis = '0;
  bit           m_push;
  bit           m_pop;
  logic [W-1:0] h_id;
  logic         h_mp;

  // Model step at each edge: drain is allowed only if the previous edge saw no freeze and work left.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_id.delete();
      q_mp.delete();
      m_drain = 1'b0;
      m_nc    = 1'b0;
      m_nc2   = 1'b0;
      m_bid   = '0;
      m_upd   = '0;
      m_mis   = '0;
    end else if (rdy) begin
      m_push = rob_upd_valid && (q_id.size() < DEPTH);
      m_pop  = m_drain && (q_id.size() > 0);
      if (m_pop) begin
        h_id  = q_id.pop_front();
        h_mp  = q_mp.pop_front();
        m_nc  = h_mp;
        m_nc2 = !h_mp;
        m_bid = h_id;
      end else begin
        m_nc  = 1'b0;
        m_nc2 = 1'b0;
      end
      if (cnt_clr) begin
        m_upd = '0;
        m_mis = '0;
      end else if (m_pop) begin
        m_upd = m_upd + 16'd1;
        if (h_mp && (m_mis != 16'hFFFF)) m_mis = m_mis + 16'd1;
      end
      if (m_push) begin
        q_id.push_back(rob_upd_id);
        q_mp.push_back(rob_upd_mispred);
      end
      m_drain = !freeze && (q_id.size() > 0);
    end else begin
      m_nc  = 1'b0;
      m_nc2 = 1'b0;
    end
  end

  bit exp_ready;
  bit exp_lp;

  // Every falling edge: compare all DUT outputs with the model.
  always @(negedge clk) begin
    exp_ready = (q_id.size() != DEPTH) && rdy && rst;
    exp_lp    = (m_nc || m_nc2) && (m_bid == lookup_id);
    foreach (q_id[k]) if (q_id[k] == lookup_id) exp_lp = 1'b1;
    checkOutput("ready", 32'(rob_upd_ready), 32'(exp_ready));
    checkOutput("needchange", 32'(bht_needchange), 32'(m_nc));
    checkOutput("needchange2", 32'(bht_needchange2), 32'(m_nc2));
    checkOutput("bht_id", 32'(bht_id), 32'(m_bid));
    checkOutput("lookup_pending", 32'(lookup_pending), 32'(exp_lp));
    checkOutput("upd_cnt", 32'(upd_cnt), 32'(m_upd));
    checkOutput("mispred_cnt", 32'(mispred_cnt), 32'(m_mis));
  end

  // Record every issued pulse so ordering and loss can be checked per scenario.
  logic [W-1:0] seen_ids[$];
  logic [W-1:0] exp_ids[$];
  always @(negedge clk) begin
    if (bht_needchange || bht_needchange2) seen_ids.push_back(bht_id);
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  bit frz_r;
  bit rd_r;
  logic [31:0] seen_val;

  // Directed scenarios, randomized traffic, then the summary.
  initial begin
    #3;
    checkOutput("rst_ready", 32'(rob_upd_ready), 0);
    checkOutput("rst_nc", 32'(bht_needchange), 0);
    checkOutput("rst_upd", 32'(upd_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idleCycle(1'b0, '0);
    idleCycle(1'b0, '0);

    // Single mispredicted update: pulse for exactly one cycle after the second edge.
    applyStimulus(1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 8'h12);
    idleCycle(1'b0, 8'h12);
    @(negedge clk);
    checkOutput("s1_no_pulse_yet", 32'(bht_needchange), 0);
    checkOutput("s1_pending_buf", 32'(lookup_pending), 1);
    idleCycle(1'b0, 8'h12);
    @(negedge clk);
    checkOutput("s1_pulse", 32'(bht_needchange), 1);
    checkOutput("s1_pulse2", 32'(bht_needchange2), 0);
    checkOutput("s1_id", 32'(bht_id), 32'h12);
    checkOutput("s1_upd", 32'(upd_cnt), 1);
    checkOutput("s1_mis", 32'(mispred_cnt), 1);
    idleCycle(1'b0, 8'h12);
    @(negedge clk);
    checkOutput("s1_pulse_end", 32'(bht_needchange), 0);
    checkOutput("s1_id_held", 32'(bht_id), 32'h12);
    checkOutput("s1_pending_clr", 32'(lookup_pending), 0);

    // Frozen fill: four accepted, fifth refused, then four ordered pulses.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h21 + i), i[0], 1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      checkOutput("s2_ready", 32'(rob_upd_ready), (i < 4) ? 1 : 0);
    end
    idleCycle(1'b0, '0);
    idleCycle(1'b0, '0);
    @(negedge clk);
    checkOutput("s2_gap", 32'(bht_needchange || bht_needchange2), 0);
    for (int i = 0; i < 4; i++) begin
      idleCycle(1'b0, '0);
      @(negedge clk);
      checkOutput("s2_pulse", 32'(bht_needchange || bht_needchange2), 1);
      checkOutput("s2_order", 32'(bht_id), 32'(8'h21 + i));
      checkOutput("s2_kind", 32'(bht_needchange), 32'(i & 1));
    end
    idleCycle(1'b0, '0);
    @(negedge clk);
    checkOutput("s2_done", 32'(bht_needchange || bht_needchange2), 0);

    // Lookup against a buffered frozen entry, then against its pulse.
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 8'h40);
    idleCycle(1'b1, 8'h40);
    @(negedge clk);
    checkOutput("s3_pending_frozen", 32'(lookup_pending), 1);
    idleCycle(1'b1, 8'h40);
    @(negedge clk);
    checkOutput("s3_pending_hold", 32'(lookup_pending), 1);
    idleCycle(1'b0, 8'h40);
    idleCycle(1'b0, 8'h40);
    @(negedge clk);
    checkOutput("s3_pending_pre", 32'(lookup_pending), 1);
    idleCycle(1'b0, 8'h40);
    @(negedge clk);
    checkOutput("s3_pulse2", 32'(bht_needchange2), 1);
    checkOutput("s3_pending_pulse", 32'(lookup_pending), 1);
    idleCycle(1'b0, 8'h40);
    @(negedge clk);
    checkOutput("s3_pending_gone", 32'(lookup_pending), 0);

    // Streaming with a two-cycle rdy=0 window.
    seen_ids.delete();
    exp_ids.delete();
    for (int i = 0; i < 14; i++) begin
      rd_r = !((i == 6) || (i == 7));
      applyStimulus(1'b1, 8'(8'h50 + i), i[1], 1'b0, rd_r, 1'b0, '0);
      if (rd_r) exp_ids.push_back(8'(8'h50 + i));
      @(negedge clk);
      checkOutput("s4_pulse_window", 32'(bht_needchange || bht_needchange2),
                  ((i >= 2 && i <= 6) || i >= 9) ? 1 : 0);
    end
    repeat (4) idleCycle(1'b0, '0);
    @(negedge clk);
    checkOutput("s4_count", 32'(seen_ids.size()), 32'(exp_ids.size()));
    for (int k = 0; k < exp_ids.size(); k++) begin
      seen_val = (k < seen_ids.size()) ? 32'(seen_ids[k]) : 32'hFFFF_FFFF;
      checkOutput("s4_order", seen_val, 32'(exp_ids[k]));
    end

    // Randomized traffic with freeze bursts and rdy stalls.
    frz_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) frz_r = !frz_r;
      rd_r = ($urandom_range(0, 99) < 85);
      applyStimulus($urandom_range(0, 99) < 60,
                    ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)),
                    $urandom_range(0, 1) == 1, frz_r, rd_r,
                    rd_r && ($urandom_range(0, 99) < 2), 8'($urandom_range(0, 7)));
    end
    repeat (8) idleCycle(1'b0, '0);

    // Saturation: 65540 mispredicted updates from a cleared start.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    for (int c = 0; c < 65540; c++) begin
      applyStimulus(1'b1, 8'(c), 1'b1, 1'b0, 1'b1, 1'b0, '0);
    end
    repeat (4) idleCycle(1'b0, '0);
    @(negedge clk);
    checkOutput("s5_mis_sat", 32'(mispred_cnt), 32'hFFFF);
    checkOutput("s5_upd_wrap", 32'(upd_cnt), 4);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    idleCycle(1'b0, '0);
    @(negedge clk);
    checkOutput("s5_clr_pulse", 32'(bht_needchange), 1);
    checkOutput("s5_clr_id", 32'(bht_id), 32'h77);
    checkOutput("s5_clr_upd", 32'(upd_cnt), 0);
    checkOutput("s5_clr_mis", 32'(mispred_cnt), 0);

    // Reset with three queued entries.
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    idleCycle(1'b0, '0);
    idleCycle(1'b0, '0);
    applyStimulus(1'b1, 8'h61, 1'b1, 1'b1, 1'b1, 1'b0, 8'h61);
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b1, 1'b1, 1'b0, 8'h61);
    applyStimulus(1'b1, 8'h63, 1'b1, 1'b1, 1'b1, 1'b0, 8'h61);
    idleCycle(1'b1, 8'h61);
    @(negedge clk);
    checkOutput("s6_pre_upd", 32'(upd_cnt), 1);
    checkOutput("s6_pre_pending", 32'(lookup_pending), 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("s6_rst_ready", 32'(rob_upd_ready), 0);
    checkOutput("s6_rst_nc", 32'(bht_needchange), 0);
    checkOutput("s6_rst_nc2", 32'(bht_needchange2), 0);
    checkOutput("s6_rst_id", 32'(bht_id), 0);
    checkOutput("s6_rst_upd", 32'(upd_cnt), 0);
    checkOutput("s6_rst_mis", 32'(mispred_cnt), 0);
    checkOutput("s6_rst_pending", 32'(lookup_pending), 0);
    seen_ids.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (8) idleCycle(1'b0, 8'h61);
    @(negedge clk);
    checkOutput("s6_no_pulses", 32'(seen_ids.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
